riscv_dmi_responder: RTL and testbench

- Debug-Module-side endpoint of the DMI link: accepts DMI requests (addr/data/op), executes them as single register accesses on a simple DM register bus, and returns a DMI response (data + status op).
- Sits between the DTM DMI request/response channels and the DM register file.
- Adds op decoding, a backend handshake, a watchdog timeout and a one-entry response holding stage.

---
 rtl/riscv_dmi_responder.sv | 186 ++++++++++++++++++
 tb/tb_riscv_dmi_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmi_responder.sv
// DM-side DMI endpoint: turns one DMI request into a single DM register-bus
// access, guards it with a watchdog and holds the response until consumed.
module riscv_dmi_responder #(
    parameter int unsigned ADDR_WIDTH     = 7,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    input  logic [1:0]            req_op_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic [1:0]            resp_op_o,
    output logic                  reg_valid_o,
    input  logic                  reg_ready_i,
    output logic                  reg_we_o,
    output logic [ADDR_WIDTH-1:0] reg_addr_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    input  logic                  reg_rvalid_i,
    input  logic [DATA_WIDTH-1:0] reg_rdata_i,
    input  logic                  reg_err_i,
    output logic                  reg_abort_o,
    output logic                  busy_o,
    output logic [1:0]            state_o
);

    // Handshake rule for every channel: a transfer happens on a rising clk_i
    // edge where valid and ready are both high; a valid source holds its
    // payload stable until that edge.

    localparam logic [1:0] OP_NOP       = 2'd0;
    localparam logic [1:0] OP_READ      = 2'd1;
    localparam logic [1:0] OP_WRITE     = 2'd2;
    localparam logic [1:0] OP_RSVD      = 2'd3;
    localparam logic [1:0] RESP_SUCCESS = 2'd0;
    localparam logic [1:0] RESP_FAILED  = 2'd2;

    localparam bit          WD_EN     = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CNT_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam int unsigned CNT_LIMIT = WD_EN ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        WAIT_RESP = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [1:0]            op_q;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [1:0]            resp_op_q, resp_op_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  abort_q, abort_d;
    logic                  capture;
    logic                  complete;
    logic                  wait_cycle;
    logic                  fail_abort;

    always_comb begin
        state_d     = state_q;
        resp_data_d = resp_data_q;
        resp_op_d   = resp_op_q;
        cnt_d       = cnt_q;
        abort_d     = 1'b0;
        capture     = 1'b0;
        complete    = 1'b0;
        wait_cycle  = 1'b0;
        fail_abort  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    case (req_op_i)
                        OP_NOP: begin
                            state_d     = RESP;
                            resp_data_d = '0;
                            resp_op_d   = RESP_SUCCESS;
                        end
                        OP_RSVD: begin
                            state_d     = RESP;
                            resp_data_d = '0;
                            resp_op_d   = RESP_FAILED;
                        end
                        default: state_d = ACCESS;
                    endcase
                end
            end
            ACCESS: begin
                // Once the abort pulse is out, any late completion is stale.
                if (abort_q) begin
                    fail_abort = 1'b1;
                end else if (reg_ready_i && reg_rvalid_i) begin
                    complete = 1'b1;
                end else begin
                    wait_cycle = 1'b1;
                    if (reg_ready_i) begin
                        state_d = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (abort_q) begin
                    fail_abort = 1'b1;
                end else if (reg_rvalid_i) begin
                    complete = 1'b1;
                end else begin
                    wait_cycle = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            state_d     = RESP;
            resp_op_d   = reg_err_i ? RESP_FAILED : RESP_SUCCESS;
            resp_data_d = (!reg_err_i && op_q == OP_READ) ? reg_rdata_i : '0;
        end

        if (fail_abort) begin
            state_d     = RESP;
            resp_data_d = '0;
            resp_op_d   = RESP_FAILED;
        end

        // Expiry raises abort for the next cycle; the move to RESP follows it.
        if (wait_cycle && WD_EN) begin
            if (cnt_q == CNT_W'(CNT_LIMIT)) begin
                abort_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            op_q        <= OP_NOP;
            resp_data_q <= '0;
            resp_op_q   <= RESP_SUCCESS;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            resp_data_q <= resp_data_d;
            resp_op_q   <= resp_op_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            if (capture) begin
                addr_q <= req_addr_i;
                data_q <= req_data_i;
                op_q   <= req_op_i;
            end
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign resp_data_o  = resp_data_q;
    assign resp_op_o    = resp_op_q;
    assign reg_valid_o  = (state_q == ACCESS) && !abort_q;
    assign reg_we_o     = (state_q == ACCESS) && !abort_q && (op_q == OP_WRITE);
    assign reg_addr_o   = addr_q;
    assign reg_wdata_o  = data_q;
    assign reg_abort_o  = abort_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_riscv_dmi_responder.sv
// Directed bench for riscv_dmi_responder: READ/WRITE/NOP/reserved ops,
// backend error, watchdog expiry and asynchronous reset mid-operation.
module tb_riscv_dmi_responder;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_data_i = '0;
    logic [1:0]    req_op_i = '0;
    logic          resp_valid_o;
    logic          resp_ready_i = 1'b0;
    logic [DW-1:0] resp_data_o;
    logic [1:0]    resp_op_o;
    logic          reg_valid_o;
    logic          reg_ready_i = 1'b0;
    logic          reg_we_o;
    logic [AW-1:0] reg_addr_o;
    logic [DW-1:0] reg_wdata_o;
    logic          reg_rvalid_i = 1'b0;
    logic [DW-1:0] reg_rdata_i = '0;
    logic          reg_err_i = 1'b0;
    logic          reg_abort_o;
    logic          busy_o;
    logic [1:0]    state_o;

    int checks = 0;
    int errors = 0;

    riscv_dmi_responder #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_op_i    (req_op_i),
        .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i),
        .resp_data_o (resp_data_o),
        .resp_op_o   (resp_op_o),
        .reg_valid_o (reg_valid_o),
        .reg_ready_i (reg_ready_i),
        .reg_we_o    (reg_we_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_rvalid_i(reg_rvalid_i),
        .reg_rdata_i (reg_rdata_i),
        .reg_err_i   (reg_err_i),
        .reg_abort_o (reg_abort_o),
        .busy_o      (busy_o),
        .state_o     (state_o)
    );

    // Clock and reset
    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents a request for one cycle (cycle c0); returns at cycle c1.
    task automatic send(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_addr_i  = addr;
        req_data_i  = data;
        cyc();
        req_valid_i = 1'b0;
        req_op_i    = 2'd0;
        req_addr_i  = '0;
        req_data_i  = '0;
    endtask

    task automatic consume();
        resp_ready_i = 1'b1;
        cyc();
        resp_ready_i = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (2) cyc();
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_reg_valid", reg_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_abort", reg_abort_o, 0);
        chk("rst_resp_data", resp_data_o, 0);
        chk("rst_reg_addr", reg_addr_o, 0);
        chk("rst_state", state_o, 0);
        rstn_i = 1'b1;
        cyc();

        // READ 0x11, ready at c1, rvalid at c3
        chk("rd_idle_ready", req_ready_o, 1);
        send(2'd1, 7'h11, 32'h0);
        chk("rd_c1_reg_valid", reg_valid_o, 1);
        chk("rd_c1_reg_addr", reg_addr_o, 32'h11);
        chk("rd_c1_reg_we", reg_we_o, 0);
        chk("rd_c1_req_ready", req_ready_o, 0);
        chk("rd_c1_busy", busy_o, 1);
        reg_ready_i = 1'b1;
        cyc();
        reg_ready_i = 1'b0;
        chk("rd_c2_reg_valid", reg_valid_o, 0);
        chk("rd_c2_state", state_o, 2);
        cyc();
        chk("rd_c3_resp_valid", resp_valid_o, 0);
        reg_rvalid_i = 1'b1;
        reg_rdata_i  = 32'hDEADBEEF;
        cyc();
        reg_rvalid_i = 1'b0;
        reg_rdata_i  = '0;
        chk("rd_c4_resp_valid", resp_valid_o, 1);
        chk("rd_c4_resp_data", resp_data_o, 32'hDEADBEEF);
        chk("rd_c4_resp_op", resp_op_o, 0);
        chk("rd_c4_req_ready", req_ready_o, 0);
        cyc();
        chk("rd_c5_hold_valid", resp_valid_o, 1);
        chk("rd_c5_hold_data", resp_data_o, 32'hDEADBEEF);
        chk("rd_c5_req_ready", req_ready_o, 0);
        consume();
        chk("rd_c6_resp_valid", resp_valid_o, 0);
        chk("rd_c6_req_ready", req_ready_o, 1);

        // NOP then reserved op
        send(2'd0, 7'h22, 32'h99);
        chk("nop_resp_valid", resp_valid_o, 1);
        chk("nop_resp_data", resp_data_o, 0);
        chk("nop_resp_op", resp_op_o, 0);
        chk("nop_reg_valid", reg_valid_o, 0);
        consume();
        chk("nop_back_idle", req_ready_o, 1);
        send(2'd3, 7'h23, 32'h5);
        chk("rsvd_resp_valid", resp_valid_o, 1);
        chk("rsvd_resp_op", resp_op_o, 2);
        chk("rsvd_resp_data", resp_data_o, 0);
        chk("rsvd_reg_valid", reg_valid_o, 0);
        consume();

        // Completion in the expiry cycle wins (rvalid at c4, count 3)
        send(2'd1, 7'h06, 32'h0);
        reg_ready_i = 1'b1;
        cyc();
        reg_ready_i = 1'b0;
        cyc();
        cyc();
        chk("win_c4_abort", reg_abort_o, 0);
        reg_rvalid_i = 1'b1;
        reg_rdata_i  = 32'hCAFEF00D;
        cyc();
        reg_rvalid_i = 1'b0;
        reg_rdata_i  = '0;
        chk("win_c5_abort", reg_abort_o, 0);
        chk("win_c5_resp_valid", resp_valid_o, 1);
        chk("win_c5_resp_data", resp_data_o, 32'hCAFEF00D);
        chk("win_c5_resp_op", resp_op_o, 0);
        consume();
        chk("win_c6_abort", reg_abort_o, 0);

        // Watchdog expiry: abort at c5, FAILED response at c6, stray rvalid ignored
        send(2'd1, 7'h05, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("to_c%0d_abort", c), reg_abort_o, 0);
            chk($sformatf("to_c%0d_reg_valid", c), reg_valid_o, 1);
            cyc();
        end
        chk("to_c5_abort", reg_abort_o, 1);
        chk("to_c5_resp_valid", resp_valid_o, 0);
        chk("to_c5_reg_valid", reg_valid_o, 0);
        reg_rvalid_i = 1'b1;
        reg_rdata_i  = 32'h55;
        cyc();
        chk("to_c6_abort", reg_abort_o, 0);
        chk("to_c6_resp_valid", resp_valid_o, 1);
        chk("to_c6_resp_op", resp_op_o, 2);
        chk("to_c6_resp_data", resp_data_o, 0);
        cyc();
        chk("to_c7_resp_op", resp_op_o, 2);
        chk("to_c7_resp_data", resp_data_o, 0);
        reg_rvalid_i = 1'b0;
        reg_rdata_i  = '0;
        consume();
        chk("to_c8_busy", busy_o, 0);
        chk("to_c8_resp_valid", resp_valid_o, 0);

        // WRITE 0x10, ready and rvalid at c1
        send(2'd2, 7'h10, 32'h80000001);
        chk("wr_c1_reg_valid", reg_valid_o, 1);
        chk("wr_c1_reg_we", reg_we_o, 1);
        chk("wr_c1_reg_addr", reg_addr_o, 32'h10);
        chk("wr_c1_reg_wdata", reg_wdata_o, 32'h80000001);
        reg_ready_i  = 1'b1;
        reg_rvalid_i = 1'b1;
        reg_rdata_i  = 32'hFFFFFFFF;
        cyc();
        reg_ready_i  = 1'b0;
        reg_rvalid_i = 1'b0;
        reg_rdata_i  = '0;
        chk("wr_c2_resp_valid", resp_valid_o, 1);
        chk("wr_c2_resp_data", resp_data_o, 0);
        chk("wr_c2_resp_op", resp_op_o, 0);
        chk("wr_c2_reg_valid", reg_valid_o, 0);
        consume();

        // Reset while in WAIT_RESP
        send(2'd1, 7'h07, 32'h0);
        reg_ready_i = 1'b1;
        cyc();
        reg_ready_i = 1'b0;
        chk("rw_state_wait", state_o, 2);
        #2 rstn_i = 1'b0;
        #1;
        chk("rw_busy", busy_o, 0);
        chk("rw_req_ready", req_ready_o, 1);
        chk("rw_state", state_o, 0);
        cyc();
        rstn_i = 1'b1;

        // Reset while response held with resp_ready_i low
        send(2'd1, 7'h08, 32'h0);
        reg_ready_i  = 1'b1;
        reg_rvalid_i = 1'b1;
        reg_rdata_i  = 32'h77;
        cyc();
        reg_ready_i  = 1'b0;
        reg_rvalid_i = 1'b0;
        reg_rdata_i  = '0;
        cyc();
        chk("rr_held_valid", resp_valid_o, 1);
        chk("rr_held_data", resp_data_o, 32'h77);
        #2 rstn_i = 1'b0;
        #1;
        chk("rr_resp_valid", resp_valid_o, 0);
        chk("rr_resp_data", resp_data_o, 0);
        chk("rr_req_ready", req_ready_o, 1);
        cyc();
        rstn_i = 1'b1;

        // READ after reset completes normally
        send(2'd1, 7'h12, 32'h0);
        chk("pr_reg_valid", reg_valid_o, 1);
        chk("pr_reg_addr", reg_addr_o, 32'h12);
        reg_ready_i  = 1'b1;
        reg_rvalid_i = 1'b1;
        reg_rdata_i  = 32'h0BADF00D;
        cyc();
        reg_ready_i  = 1'b0;
        reg_rvalid_i = 1'b0;
        reg_rdata_i  = '0;
        chk("pr_resp_valid", resp_valid_o, 1);
        chk("pr_resp_data", resp_data_o, 32'h0BADF00D);
        chk("pr_resp_op", resp_op_o, 0);
        consume();

        // READ with backend error
        send(2'd1, 7'h04, 32'h0);
        reg_ready_i  = 1'b1;
        reg_rvalid_i = 1'b1;
        reg_err_i    = 1'b1;
        reg_rdata_i  = 32'h1234;
        cyc();
        reg_ready_i  = 1'b0;
        reg_rvalid_i = 1'b0;
        reg_err_i    = 1'b0;
        reg_rdata_i  = '0;
        chk("err_resp_valid", resp_valid_o, 1);
        chk("err_resp_op", resp_op_o, 2);
        chk("err_resp_data", resp_data_o, 0);
        consume();
        chk("err_back_idle", req_ready_o, 1);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
